// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: ALUOp/funct codes, FSM states, op decode.
// DIVU decode is present only when ALU_SEQ_DIVU_EN is defined.
package alu_seq_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam int ITERS = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_BAD
  } op_e;

  function automatic op_e decode(input logic [1:0] alu_op, input logic [5:0] funct);
    op_e op;
    op = OP_BAD;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:   op = OP_ADD;
          FN_SUB:   op = OP_SUB;
          FN_AND:   op = OP_AND;
          FN_OR:    op = OP_OR;
          FN_SLT:   op = OP_SLT;
          FN_MFHI:  op = OP_MFHI;
          FN_MFLO:  op = OP_MFLO;
          FN_MULTU: op = OP_MULTU;
`ifdef ALU_SEQ_DIVU_EN
          FN_DIVU:  op = OP_DIVU;
`endif
          default:  op = OP_BAD;
        endcase
      end
      default: op = OP_BAD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_step.sv
// One iteration of the multi-cycle datapath: shift-add multiply or restoring divide.
// The divide path is built only when ALU_SEQ_DIVU_EN is defined.
module alu_seq_step
  import alu_seq_pkg::*;
(
  input  logic        is_div,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  output logic [31:0] hi_nx,
  output logic [31:0] lo_nx
);

  logic [32:0] sum;
`ifdef ALU_SEQ_DIVU_EN
  logic [32:0] shifted;
  logic [33:0] diff;
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  always_comb begin
    // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
    sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : 32'd0)};
    hi_nx = sum[32:1];
    lo_nx = {sum[0], lo[31:1]};
`ifdef ALU_SEQ_DIVU_EN
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    shifted = {hi, lo[31]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    if (is_div) begin
      if (!diff[33]) begin
        hi_nx = diff[31:0];
        lo_nx = {lo[30:0], 1'b1};
      end else begin
        hi_nx = shifted[31:0];
        lo_nx = {lo[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/alu_sequencer.sv
// MIPS-style ALU sequencer: single-cycle ALU ops plus 32-iteration MULTU (and DIVU
// when ALU_SEQ_DIVU_EN is defined) into internal HI/LO registers.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid,
  output logic        err,
  output logic        busy
);

  state_e      state;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] wk_hi, wk_lo, opnd;
  logic        is_div;
  logic [31:0] hi_nx, lo_nx;
  logic [31:0] alu_res;
  op_e         op;

  assign op = decode(alu_op, funct);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {31'd0, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  alu_seq_step u_step (
    .is_div (is_div),
    .hi     (wk_hi),
    .lo     (wk_lo),
    .opnd   (opnd),
    .hi_nx  (hi_nx),
    .lo_nx  (lo_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      wk_hi     <= '0;
      wk_lo     <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          case (op)
            OP_MULTU: begin
              wk_hi    <= '0;
              wk_lo    <= b;
              opnd     <= a;
              is_div   <= 1'b0;
              cnt      <= '0;
              state    <= S_RUN;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end
`ifdef ALU_SEQ_DIVU_EN
            OP_DIVU: begin
              wk_hi    <= '0;
              wk_lo    <= a;
              opnd     <= b;
              is_div   <= 1'b1;
              cnt      <= '0;
              state    <= S_RUN;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end
`endif
            OP_BAD: begin
              result    <= '0;
              err       <= 1'b1;
              out_valid <= 1'b1;
            end
            default: begin
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          endcase
        end
        S_RUN: begin
          wk_hi <= hi_nx;
          wk_lo <= lo_nx;
          cnt   <= cnt + 5'd1;
          // Last iteration commits straight into HI/LO as DONE is entered.
          if (cnt == 5'(ITERS - 1)) begin
            hi    <= hi_nx;
            lo    <= lo_nx;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          result    <= lo;
          out_valid <= 1'b1;
          state     <= S_IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed cases plus random ops against a
// plain-arithmetic HI/LO model; a negedge monitor pops and checks each result.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result;
  logic        out_valid, err, busy;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .result(result),
    .out_valid(out_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: arithmetic straight from the op definitions.
  task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] r, output logic e,
                       output int lat);
    r = '0; e = 1'b0; lat = 0;
    if (op == 2'd0) r = x + y;
    else if (op == 2'd1) r = x - y;
    else if (op == 2'd3) e = 1'b1;
    else begin
      case (fn)
        6'h20: r = x + y;
        6'h22: r = x - y;
        6'h24: r = x & y;
        6'h25: r = x | y;
        6'h2a: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h19: begin
          {m_hi, m_lo} = 64'(x) * 64'(y);
          r = m_lo; lat = 33;
        end
        6'h1b: begin
`ifdef ALU_SEQ_DIVU_EN
          if (y == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = x; end
          else begin m_lo = x / y; m_hi = x % y; end
          r = m_lo; lat = 33;
`else
          e = 1'b1;
`endif
        end
        default: e = 1'b1;
      endcase
    end
  endtask

  // Called at posedge+1; waits for in_ready (junk requests meanwhile), then issues one op.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x,
                       input logic [31:0] y);
    int n;
    int lat;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      alu_op = 2'($urandom); funct = 6'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1; alu_op = op; funct = fn; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    model(op, fn, x, y, e.res, e.err, lat);
    e.cyc = cyc + lat;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_res = '0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("result", 64'(result), 64'(mon_e.res));
        chk("err", 64'(err), 64'(mon_e.err));
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
      last_res = result;
    end else begin
      chk("err_unqualified", 64'(err), 64'd0);
      chk("result_hold", 64'(result), 64'(last_res));
    end
  end

  logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h10, 6'h12, 6'h19, 6'h1b, 6'h3f};

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    issue(2'b10, 6'h22, 32'd7, 32'd9);
    issue(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 6'h2a, 32'd1, 32'hFFFF_FFFF);

    issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    while (!in_ready && n < 50) begin
      chk("busy_while_run", 64'(busy), 64'd1);
      n++;
      @(posedge clk); #1;
    end
    chk("multu_ready_low", 64'(n), 64'd33);
    issue(2'b10, 6'h10, 32'd0, 32'd0);

    // Abort a multiply mid-run; accept attempted in the reset cycle must be dropped.
    issue(2'b10, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    q.delete(); m_hi = '0; m_lo = '0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    repeat (40) @(posedge clk);
    #1 issue(2'b10, 6'h12, 32'd0, 32'd0);

    issue(2'b11, 6'h20, 32'd5, 32'd6);
    issue(2'b10, 6'h1b, 32'd100, 32'd7);
    issue(2'b10, 6'h10, 32'd0, 32'd0);
    issue(2'b10, 6'h1b, 32'd100, 32'd0);
    issue(2'b10, 6'h10, 32'd0, 32'd0);
    issue(2'b10, 6'h12, 32'd0, 32'd0);

    for (int i = 0; i < 5; i++)
      issue(2'b10, fns[i], $urandom, $urandom);
    issue(2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1);
    issue(2'b01, 6'h00, 32'd0, 32'd1);

    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) issue(2'b00, 6'($urandom), $urandom, $urandom);
      else if (sel == 1) issue(2'b01, 6'($urandom), $urandom, $urandom);
      else if (sel == 2) issue(2'b11, 6'($urandom), $urandom, $urandom);
      else if (sel == 3) issue(2'b10, 6'($urandom), $urandom, $urandom);
      else if (sel == 4 && $urandom_range(0, 3) == 0)
        issue(2'b10, fns[7 + int'($urandom_range(0, 1))], $urandom,
              ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
      else issue(2'b10, fns[$urandom_range(0, 6)], $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
